// File: rtl/wallace_pkg.sv
// Shared widths and FSM encodings for the Wallace multiplier datapath.
// Imported by the accumulator stage and its helpers.
package wallace_pkg;

    localparam int OPERAND_W   = 8;
    localparam int PROD_W      = 2 * OPERAND_W;
    localparam int ACC_W_DEF   = 24;
    localparam int CNT_W_DEF   = 8;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ACCUM = 1'b1;

    function automatic logic [CNT_W_DEF-1:0] cnt_inc_sat(
        input logic [CNT_W_DEF-1:0] c
    );
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/wallace_mac_accum_sat_add.sv
// Unsigned accumulator adder with carry-out flag and optional all-ones clamp.
// Purely combinational so later accumulation stages can reuse it.
module sat_add_u #(
    parameter int ACC_W    = 24,
    parameter int PROD_W   = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] s;

    always_comb begin
        s     = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        carry = s[ACC_W];
        sum   = s[ACC_W-1:0];
        if (SATURATE && s[ACC_W]) begin
            sum = '1;
        end
    end

endmodule

// File: rtl/wallace_mac_accum.sv
// Frame accumulator behind the Wallace multiplier: sums a stream of products
// and presents sum, beat count and overflow in one registered output slot.
module wallace_mac_accum
    import wallace_pkg::*;
#(
    parameter int PROD_W   = wallace_pkg::PROD_W,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    logic             state;
    logic             state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             carry;
    logic             accept;

    sat_add_u #(
        .ACC_W    (ACC_W),
        .PROD_W   (PROD_W),
        .SATURATE (SATURATE)
    ) u_add (
        .a     (acc),
        .b     (in_product),
        .sum   (acc_next),
        .carry (carry)
    );

    // Slot can take a new result when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_next = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        state_next = state;
        if (accept) begin
            unique case (state)
                ST_IDLE:  state_next = in_last ? ST_IDLE : ST_ACCUM;
                ST_ACCUM: state_next = in_last ? ST_IDLE : ST_ACCUM;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    out_sum      <= acc_next;
                    out_count    <= cnt_next;
                    out_overflow <= ovf | carry;
                    out_valid    <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                    ovf          <= 1'b0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    ovf <= ovf | carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_mac_accum.sv
// Directed bench for wallace_mac_accum: one saturating and one wrapping
// instance driven by the same stimulus.
module tb_wallace_mac_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_product;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  in_ready_w;
    logic        out_valid, out_valid_w;
    logic [23:0] out_sum,   out_sum_w;
    logic [7:0]  out_count, out_count_w;
    logic        out_overflow, out_overflow_w;

    int n_run  = 0;
    int n_fail = 0;

    wallace_mac_accum #(.SATURATE(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    wallace_mac_accum #(.SATURATE(1'b0)) dut_w (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_w),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid_w),
        .out_ready    (out_ready),
        .out_sum      (out_sum_w),
        .out_count    (out_count_w),
        .out_overflow (out_overflow_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] p, input logic last);
        int n;
        n = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            chk("idle_ovalid", {31'd0, out_valid}, 32'd0);
            chk("idle_iready", {31'd0, in_ready}, 32'd1);
            chk("idle_sum", {8'd0, out_sum}, 32'd0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {8'd0, out_sum}, 32'd0);
        chk("rst_cnt", {24'd0, out_count}, 32'd0);

        // Three beats of 255*255
        send(16'd65025, 1'b0);
        chk("f3_mid_ovalid", {31'd0, out_valid}, 32'd0);
        send(16'd65025, 1'b0);
        send(16'd65025, 1'b1);
        chk("f3_ovalid", {31'd0, out_valid}, 32'd1);
        chk("f3_sum", {8'd0, out_sum}, 32'd195075);
        chk("f3_cnt", {24'd0, out_count}, 32'd3);
        chk("f3_ovf", {31'd0, out_overflow}, 32'd0);
        step();
        chk("f3_pulse", {31'd0, out_valid}, 32'd0);

        send(16'd100, 1'b1);
        chk("single_ovalid", {31'd0, out_valid}, 32'd1);
        chk("single_sum", {8'd0, out_sum}, 32'd100);
        chk("single_cnt", {24'd0, out_count}, 32'd1);
        step();

        for (int i = 0; i < 259; i++) send(16'd65025, i == 258);
        chk("sat_sum", {8'd0, out_sum}, 32'hFFFFFF);
        chk("sat_cnt", {24'd0, out_count}, 32'd255);
        chk("sat_ovf", {31'd0, out_overflow}, 32'd1);
        chk("wrap_sum", {8'd0, out_sum_w}, 32'd64259);
        chk("wrap_cnt", {24'd0, out_count_w}, 32'd255);
        chk("wrap_ovf", {31'd0, out_overflow_w}, 32'd1);
        step();

        // Next frame must start from a cleared accumulator
        send(16'd42, 1'b1);
        chk("clr_sum", {8'd0, out_sum}, 32'd42);
        chk("clr_ovf", {31'd0, out_overflow}, 32'd0);
        step();

        // Gap inside a frame and zero-valued beats
        send(16'd10, 1'b0);
        step();
        step();
        send(16'd20, 1'b1);
        chk("gap_sum", {8'd0, out_sum}, 32'd30);
        chk("gap_cnt", {24'd0, out_count}, 32'd2);
        step();
        send(16'd0, 1'b0);
        send(16'd0, 1'b1);
        chk("zero_ovalid", {31'd0, out_valid}, 32'd1);
        chk("zero_sum", {8'd0, out_sum}, 32'd0);
        chk("zero_cnt", {24'd0, out_count}, 32'd2);
        step();

        // Backpressure: hold the {5,7} result while {9} is offered
        out_ready = 1'b0;
        send(16'd5, 1'b0);
        send(16'd7, 1'b1);
        in_valid   = 1'b1;
        in_product = 16'd9;
        in_last    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_iready", {31'd0, in_ready}, 32'd0);
            chk("bp_ovalid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", {8'd0, out_sum}, 32'd12);
            chk("bp_cnt", {24'd0, out_count}, 32'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_iready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("popacc_ovalid", {31'd0, out_valid}, 32'd1);
        chk("popacc_sum", {8'd0, out_sum}, 32'd9);
        chk("popacc_cnt", {24'd0, out_count}, 32'd1);
        step();
        chk("popacc_drain", {31'd0, out_valid}, 32'd0);

        // Abort a partial frame with reset
        send(16'd1000, 1'b0);
        send(16'd2000, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ovalid", {31'd0, out_valid}, 32'd0);
        send(16'd3, 1'b1);
        chk("abort_sum", {8'd0, out_sum}, 32'd3);
        chk("abort_cnt", {24'd0, out_count}, 32'd1);
        chk("abort_ovf", {31'd0, out_overflow}, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
